color_conv_job_ctrl: RTL and testbench

Job sequencer for the RGB->YCbCr streamer. It takes a frame job from the register file (source base, destination base, row geometry) and splits it into one source/sink stream transaction per row. For each row it programs the source and sink address generators, fires req_start, and waits for both streams to report done. It then advances the addresses, and on the last row it raises a completion event. It sits between the HWPE register file/control slave and the streamer's source/sink control ports.

---
 rtl/color_conv_job_ctrl_pkg.sv | 59 +++++
 rtl/color_conv_job_ctrl_addr_step.sv | 22 ++
 rtl/color_conv_job_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_color_conv_job_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_conv_job_ctrl_pkg.sv
// rtl/color_conv_job_ctrl_pkg.sv - shared types and constants for the colour-conversion job sequencer
package color_conv_package;

  localparam int unsigned PIX_PER_BEAT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [31:0] src_base;
    logic [31:0] dst_base;
    logic [31:0] src_stride;
    logic [31:0] dst_stride;
    logic [31:0] row_pix;
    logic [31:0] row_cnt;
  } job_cfg_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  // One row is a single linear line of beats; all feature/loop fields stay zero.
  function automatic ctrl_addressgen_t row_agen(input logic [31:0] base,
                                                input logic [31:0] beats,
                                                input logic [15:0] stride);
    ctrl_addressgen_t c;
    c             = '0;
    c.base_addr   = base;
    c.trans_size  = beats;
    c.line_stride = stride;
    c.line_length = beats[15:0];
    return c;
  endfunction

endpackage

// File: rtl/color_conv_job_ctrl_addr_step.sv
// rtl/color_conv_job_ctrl_addr_step.sv - per-stream row address register with stride step
module color_conv_addr_step (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] base,
  input  logic [31:0] stride,
  output logic [31:0] addr
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= addr + stride;
    end
  end

endmodule

// File: rtl/color_conv_job_ctrl.sv
// rtl/color_conv_job_ctrl.sv - row-by-row job sequencer for the RGB->YCbCr streamer (perf counters: COLOR_CONV_JOB_CTRL_PERF_EN)
module color_conv_job_ctrl
  import color_conv_package::*;
#(
  parameter int STREAM_WIDTH = 24 * PIX_PER_BEAT,
  parameter int ROW_CNT_W    = 16,
  parameter int PIX_CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [31:0]          src_base_i,
  input  logic [31:0]          dst_base_i,
  input  logic [PIX_CNT_W-1:0] row_pix_i,
  input  logic [ROW_CNT_W-1:0] row_cnt_i,
  input  logic [31:0]          src_stride_i,
  input  logic [31:0]          dst_stride_i,
  output ctrl_sourcesink_t     source_ctrl_o,
  input  flags_sourcesink_t    source_flags_i,
  output ctrl_sourcesink_t     sink_ctrl_o,
  input  flags_sourcesink_t    sink_flags_i,
  output logic                 clear_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ROW_CNT_W-1:0] row_idx_o,
  output logic [31:0]          perf_busy_o,
  output logic [31:0]          perf_stall_o
);

  localparam int unsigned PPB         = STREAM_WIDTH / 24;
  localparam logic [15:0] LINE_STRIDE = 16'(STREAM_WIDTH / 8);

  state_e               state_q;
  job_cfg_t             cfg_q;
  logic [ROW_CNT_W-1:0] row_idx_q;
  logic                 src_seen_q, snk_seen_q;
  logic                 clear_q, busy_q, done_q, err_q, req_q;
  ctrl_addressgen_t     agen_src_q, agen_snk_q;
  logic [31:0]          src_addr, dst_addr;

  logic        cfg_bad, both_ready, both_done, last_row, load, step;
  logic [31:0] beats;

  assign cfg_bad    = (row_cnt_i == '0) || (row_pix_i == '0) ||
                      ((32'(row_pix_i) % PPB) != 32'd0);
  assign both_ready = source_flags_i.ready_start && sink_flags_i.ready_start;
  assign both_done  = (src_seen_q || source_flags_i.done) && (snk_seen_q || sink_flags_i.done);
  assign last_row   = 32'(row_idx_q) == (cfg_q.row_cnt - 32'd1);
  assign beats      = cfg_q.row_pix / PPB;
  assign load       = (state_q == ST_CLEAR);
  assign step       = (state_q == ST_NEXT) && !abort_i && !last_row;

  color_conv_addr_step u_src_step (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .load   (load),
    .step   (step),
    .base   (cfg_q.src_base),
    .stride (cfg_q.src_stride),
    .addr   (src_addr)
  );

  color_conv_addr_step u_dst_step (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .load   (load),
    .step   (step),
    .base   (cfg_q.dst_base),
    .stride (cfg_q.dst_stride),
    .addr   (dst_addr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      row_idx_q  <= '0;
      src_seen_q <= 1'b0;
      snk_seen_q <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      agen_src_q <= '0;
      agen_snk_q <= '0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      // Abort has priority over every in-flight event, including a final done.
      if (abort_i && state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        clear_q    <= 1'b1;
        busy_q     <= 1'b0;
        row_idx_q  <= '0;
        src_seen_q <= 1'b0;
        snk_seen_q <= 1'b0;
        agen_src_q <= '0;
        agen_snk_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                cfg_q     <= '{src_base:   src_base_i,
                               dst_base:   dst_base_i,
                               src_stride: src_stride_i,
                               dst_stride: dst_stride_i,
                               row_pix:    32'(row_pix_i),
                               row_cnt:    32'(row_cnt_i)};
                state_q   <= ST_CLEAR;
                clear_q   <= 1'b1;
                busy_q    <= 1'b1;
                row_idx_q <= '0;
              end
            end
          end
          ST_CLEAR: state_q <= ST_ARM;
          ST_ARM: begin
            agen_src_q <= row_agen(src_addr, beats, LINE_STRIDE);
            agen_snk_q <= row_agen(dst_addr, beats, LINE_STRIDE);
            if (both_ready) begin
              req_q   <= 1'b1;
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (both_done) begin
              src_seen_q <= 1'b0;
              snk_seen_q <= 1'b0;
              state_q    <= ST_NEXT;
            end else begin
              if (source_flags_i.done) src_seen_q <= 1'b1;
              if (sink_flags_i.done)   snk_seen_q <= 1'b1;
            end
          end
          ST_NEXT: begin
            if (last_row) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              row_idx_q <= row_idx_q + 1'b1;
              state_q   <= ST_ARM;
            end
          end
          ST_DONE: begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            agen_src_q <= '0;
            agen_snk_q <= '0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign source_ctrl_o = '{req_start: req_q, addressgen_ctrl: agen_src_q};
  assign sink_ctrl_o   = '{req_start: req_q, addressgen_ctrl: agen_snk_q};
  assign clear_o       = clear_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign row_idx_o     = row_idx_q;

`ifdef COLOR_CONV_JOB_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || state_q == ST_CLEAR) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == ST_ARM && !both_ready && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_busy_o  = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_color_conv_job_ctrl.sv
// tb/tb_color_conv_job_ctrl.sv - self-checking bench for color_conv_job_ctrl
module tb_color_conv_job_ctrl;
  import color_conv_package::*;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [31:0]       src_base_i = '0, dst_base_i = '0, src_stride_i = '0, dst_stride_i = '0;
  logic [15:0]       row_pix_i = '0, row_cnt_i = '0;
  ctrl_sourcesink_t  source_ctrl_o, sink_ctrl_o;
  flags_sourcesink_t source_flags_i = '0, sink_flags_i = '0;
  logic              clear_o, busy_o, done_o, err_o;
  logic [15:0]       row_idx_o;
  logic [31:0]       perf_busy_o, perf_stall_o;

  int n_cmp = 0, n_bad = 0;
  int clear_cnt = 0, done_cnt = 0, err_cnt = 0, req_cnt = 0, skew_cnt = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  color_conv_job_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .src_base_i     (src_base_i),
    .dst_base_i     (dst_base_i),
    .row_pix_i      (row_pix_i),
    .row_cnt_i      (row_cnt_i),
    .src_stride_i   (src_stride_i),
    .dst_stride_i   (dst_stride_i),
    .source_ctrl_o  (source_ctrl_o),
    .source_flags_i (source_flags_i),
    .sink_ctrl_o    (sink_ctrl_o),
    .sink_flags_i   (sink_flags_i),
    .clear_o        (clear_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .row_idx_o      (row_idx_o),
    .perf_busy_o    (perf_busy_o),
    .perf_stall_o   (perf_stall_o)
  );

  // Event tallies sampled mid-cycle; the main sequence reads them #1 later.
  always @(negedge clk) begin
    if (clear_o) clear_cnt++;
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (busy_o) busy_cnt++;
    if (source_ctrl_o.req_start || sink_ctrl_o.req_start) req_cnt++;
    if (source_ctrl_o.req_start != sink_ctrl_o.req_start) skew_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] sb, db, ss, ds, input logic [15:0] pix, rows,
                      input logic ab);
    src_base_i = sb; dst_base_i = db; src_stride_i = ss; dst_stride_i = ds;
    row_pix_i = pix; row_cnt_i = rows;
    start_i = 1'b1; abort_i = ab;
    tick(1);
    start_i = 1'b0; abort_i = 1'b0;
    src_base_i = $urandom; dst_base_i = $urandom; src_stride_i = $urandom;
    dst_stride_i = $urandom; row_pix_i = 16'($urandom); row_cnt_i = 16'($urandom);
  endtask

  // mode: 0 random done delays, 1 source done 5 cycles before sink, 2 simultaneous done,
  //       3 sink back-pressure for 10 ARM cycles, 4 abort in WAIT of row 1
  task automatic run_job(input logic [31:0] sb, db, ss, ds, input logic [15:0] pix, rows,
                         input int mode);
    int c0, d0, e0, r0, s0, b0, a, b, m, got;
    logic [31:0] es, ed;
    c0 = clear_cnt; d0 = done_cnt; e0 = err_cnt; r0 = req_cnt; s0 = skew_cnt; b0 = busy_cnt;
    source_flags_i.ready_start = 1'b1;
    sink_flags_i.ready_start   = (mode != 3);
    kick(sb, db, ss, ds, pix, rows, 1'b0);
    check("clear_on_start", clear_o, 1);
    check("busy_on_start", busy_o, 1);
    if (mode == 3) begin
      tick(11);
      check("no_req_under_backpressure", req_cnt - r0, 0);
      sink_flags_i.ready_start = 1'b1;
    end
    for (int r = 0; r < int'(rows); r++) begin
      es = sb + 32'(r) * ss;
      ed = db + 32'(r) * ds;
      got = 0;
      for (int t = 0; t < 40; t++) begin
        if (source_ctrl_o.req_start) begin
          got = 1;
          break;
        end
        tick(1);
      end
      check("req_seen", got, 1);
      if (got == 0) return;
      check("sink_req_paired", sink_ctrl_o.req_start, 1);
      check("src_base", source_ctrl_o.addressgen_ctrl.base_addr, es);
      check("dst_base", sink_ctrl_o.addressgen_ctrl.base_addr, ed);
      check("src_trans_size", source_ctrl_o.addressgen_ctrl.trans_size, pix / 4);
      check("dst_trans_size", sink_ctrl_o.addressgen_ctrl.trans_size, pix / 4);
      check("line_stride", source_ctrl_o.addressgen_ctrl.line_stride, 12);
      check("line_length", sink_ctrl_o.addressgen_ctrl.line_length, pix / 4);
      check("row_idx", row_idx_o, r);
      if (mode == 1) begin a = 0; b = 5; end
      else if (mode == 2) begin a = $urandom_range(0, 4); b = a; end
      else begin a = $urandom_range(0, 6); b = $urandom_range(0, 6); end
      if (mode == 4 && r == 1) begin a = 0; b = 3; end
      m = (a > b) ? a : b;
      for (int t = 0; t <= m; t++) begin
        source_flags_i.done = (t == a);
        sink_flags_i.done   = (t == b);
        abort_i = (mode == 4 && r == 1 && t == b);
        tick(1);
      end
      source_flags_i.done = 1'b0; sink_flags_i.done = 1'b0; abort_i = 1'b0;
      check("one_req_per_row", req_cnt - r0, r + 1);
      if (mode == 4 && r == 1) begin
        check("abort_clear", clear_o, 1);
        check("abort_busy", busy_o, 0);
        tick(5);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_clear_count", clear_cnt - c0, 2);
        check("abort_row_idx", row_idx_o, 0);
        check("abort_no_more_req", req_cnt - r0, 2);
        return;
      end
    end
    got = 0;
    for (int t = 0; t < 20; t++) begin
      if (done_o) begin
        got = 1;
        break;
      end
      tick(1);
    end
    check("done_seen", got, 1);
    tick(2);
    check("done_count", done_cnt - d0, 1);
    check("clear_count", clear_cnt - c0, 1);
    check("req_count", req_cnt - r0, rows);
    check("req_skew", skew_cnt - s0, 0);
    check("no_err", err_cnt - e0, 0);
    check("idle_after_done", busy_o, 0);
    check("final_row_idx", row_idx_o, rows - 16'd1);
`ifdef COLOR_CONV_JOB_CTRL_PERF_EN
    check("perf_stall", perf_stall_o, (mode == 3) ? 10 : 0);
    check("perf_busy", perf_busy_o, busy_cnt - b0 - 1);
`else
    check("perf_stall_tied", perf_stall_o, 0);
    check("perf_busy_tied", perf_busy_o, 0);
`endif
  endtask

  initial begin
    logic [15:0] bad_pix [3];
    logic [15:0] bad_rows[3];
    int c0, e0, d0, r0, got;
    bad_pix  = '{16'd6, 16'd0, 16'd8};
    bad_rows = '{16'd3, 16'd3, 16'd0};

    tick(3);
    check("rst_clear", clear_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_row_idx", row_idx_o, 0);
    check("rst_req", {source_ctrl_o.req_start, sink_ctrl_o.req_start}, 0);
    check("rst_line_stride", source_ctrl_o.addressgen_ctrl.line_stride, 0);
    rst_ni = 1'b1;
    tick(2);

    run_job(32'h1000, 32'h8000, 32'h40, 32'h30, 16'd8, 16'd3, 0);

    for (int i = 0; i < 3; i++) begin
      c0 = clear_cnt; e0 = err_cnt;
      kick(32'h100, 32'h200, 32'h10, 32'h10, bad_pix[i], bad_rows[i], 1'b0);
      check("illegal_err", err_o, 1);
      check("illegal_busy", busy_o, 0);
      tick(3);
      check("illegal_no_clear", clear_cnt - c0, 0);
      check("illegal_err_once", err_cnt - e0, 1);
    end

    c0 = clear_cnt; e0 = err_cnt;
    kick(32'h100, 32'h200, 32'h10, 32'h10, 16'd8, 16'd2, 1'b1);
    tick(2);
    check("start_abort_busy", busy_o, 0);
    check("start_abort_no_clear", clear_cnt - c0, 0);
    check("start_abort_no_err", err_cnt - e0, 0);

    run_job(32'h4000, 32'h5000, 32'h80, 32'h60, 16'd12, 16'd3, 1);
    run_job(32'h4000, 32'h5000, 32'h80, 32'h60, 16'd12, 16'd3, 2);
    run_job(32'h6000, 32'h7000, 32'h20, 32'h20, 16'd4, 16'd2, 3);
    run_job(32'h2000, 32'h9000, 32'h100, 32'h100, 16'd16, 16'd3, 4);
    run_job(32'h3000, 32'hA000, 32'h0, 32'h0, 16'd4, 16'd1, 0);

    for (int j = 0; j < 3; j++) begin
      run_job($urandom, $urandom, $urandom, $urandom,
              16'(4 * $urandom_range(1, 40)), 16'($urandom_range(1, 4)), 0);
    end

    d0 = done_cnt;
    source_flags_i.ready_start = 1'b1; sink_flags_i.ready_start = 1'b1;
    kick(32'h1000, 32'h2000, 32'h10, 32'h10, 16'd8, 16'd2, 1'b0);
    got = 0;
    for (int t = 0; t < 40; t++) begin
      if (source_ctrl_o.req_start) begin
        got = 1;
        break;
      end
      tick(1);
    end
    check("rst_test_req_seen", got, 1);
    tick(2);
    rst_ni = 1'b0;
    tick(1);
    check("midrst_clear", clear_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_row_idx", row_idx_o, 0);
    check("midrst_req", {source_ctrl_o.req_start, sink_ctrl_o.req_start}, 0);
    check("midrst_src_base", source_ctrl_o.addressgen_ctrl.base_addr, 0);
    check("midrst_dst_trans", sink_ctrl_o.addressgen_ctrl.trans_size, 0);
    check("midrst_perf", {perf_busy_o, perf_stall_o}, 0);
    rst_ni = 1'b1;
    r0 = req_cnt;
    source_flags_i.done = 1'b1; sink_flags_i.done = 1'b1;
    tick(1);
    source_flags_i.done = 1'b0; sink_flags_i.done = 1'b0;
    tick(5);
    check("late_done_busy", busy_o, 0);
    check("late_done_no_done", done_cnt - d0, 0);
    check("late_done_no_req", req_cnt - r0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
